data_memory_mmio: RTL and testbench

//  Downstream data-memory unit serving the pipeline's memory stage: word RAM plus a small MMIO window.

---
 rtl/mem_map_pkg.sv | 39 +++
 rtl/tx_fifo.sv | 68 ++++++
 rtl/data_memory_mmio.sv | 119 +++++++++++
 tb/tb_data_memory_mmio.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_map_pkg.sv
// Purpose: shared address map, MMIO register offsets and STATUS layout for the data-memory unit.
// Latency: n/a (constants, types and a pure helper function only).
// Backpressure: n/a.
package mem_map_pkg;

  localparam logic [31:0] MMIO_BASE_ADDR = 32'hFFFF_0000;

  // Word offsets inside the MMIO window (addr[3:2])
  localparam logic [1:0] OFF_TX_DATA = 2'd0;
  localparam logic [1:0] OFF_STATUS  = 2'd1;
  localparam logic [1:0] OFF_CYCLE   = 2'd2;
  localparam logic [1:0] OFF_CTRL    = 2'd3;

  typedef enum logic [1:0] {
    REG_RAM,
    REG_MMIO,
    REG_NONE
  } region_e;

  // STATUS register bit positions
  localparam int ST_OVF_BIT   = 7;
  localparam int ST_FULL_BIT  = 6;
  localparam int ST_EMPTY_BIT = 5;
  localparam int ST_CNT_LSB   = 0;
  localparam int ST_CNT_W     = 5;

  function automatic logic [31:0] pack_status(input logic ovf, input logic full,
                                              input logic empty,
                                              input logic [ST_CNT_W-1:0] cnt);
    logic [31:0] s;
    s = '0;
    s[ST_OVF_BIT]                 = ovf;
    s[ST_FULL_BIT]                = full;
    s[ST_EMPTY_BIT]               = empty;
    s[ST_CNT_LSB +: ST_CNT_W]     = cnt;
    return s;
  endfunction

endpackage

// File: rtl/tx_fifo.sv
// Purpose: circular-buffer byte FIFO feeding the console transmitter.
// Latency: push visible at dout/~empty one cycle later; no fall-through.
// Backpressure: never stalls the writer; a push into a full FIFO without a pop is dropped and flagged.
module tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow_evt
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign count = count_q;
  assign dout  = mem[rd_ptr_q];

  // Accept/drop decision and next pointer/count; a pop frees the slot a full-FIFO push needs
  always_comb begin
    do_pop       = pop & ~empty;
    do_push      = push & (~full | do_pop);
    overflow_evt = push & full & ~do_pop;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; reset discards anything queued
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array, deliberately not reset; only slots behind wr_ptr are ever observed
  always_ff @(posedge clk) begin
    if (do_push && !reset) mem[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/data_memory_mmio.sv
// Purpose: memory-stage data RAM plus MMIO window (console TX FIFO, STATUS, CYCLE, CTRL).
// Latency: reads combinational from addr (RAM returns pre-write word); writes commit at the clk edge.
// Backpressure: none toward the pipeline; TX side is valid/ready, overflowing pushes set sticky ovf.
module data_memory_mmio #(
  parameter int unsigned  RAM_WORDS  = 1024,
  parameter int unsigned  FIFO_DEPTH = 8,
  parameter logic [31:0]  MMIO_BASE  = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_en,
  input  logic [31:0] addr,
  input  logic [31:0] mem_data,
  output logic [31:0] mem_out,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  import mem_map_pkg::*;

  localparam int AW = $clog2(RAM_WORDS);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]   ram [RAM_WORDS];
  logic [AW-1:0] word_idx;
  logic [1:0]    mmio_off;
  region_e       region;

  logic          wr_ok, fifo_push, fifo_pop, ctrl_clr;
  logic          fifo_empty, fifo_full, fifo_ovf_evt;
  logic [CW-1:0] fifo_count;

  logic          ovf_q, ovf_d;
  logic [31:0]   cycle_q, cycle_d;
  logic [31:0]   status_word;

  logic          unused_addr_lsbs;
  assign unused_addr_lsbs = ^addr[1:0];

  assign word_idx = addr[AW+1:2];
  assign mmio_off = addr[3:2];

  // Address decode: RAM occupies the bottom RAM_WORDS*4 bytes, MMIO a 16-byte window
  always_comb begin
    region = REG_NONE;
    if (addr[31:AW+2] == '0)                region = REG_RAM;
    else if (addr[31:4] == MMIO_BASE[31:4]) region = REG_MMIO;
  end

  // Write strobes; anything presented while reset is high is ignored
  always_comb begin
    wr_ok     = mem_en & ~reset;
    fifo_push = wr_ok & (region == REG_MMIO) & (mmio_off == OFF_TX_DATA);
    ctrl_clr  = wr_ok & (region == REG_MMIO) & (mmio_off == OFF_CTRL) & mem_data[0];
    fifo_pop  = tx_valid & tx_ready;
  end

  tx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk          (clk),
    .reset        (reset),
    .push         (fifo_push),
    .din          (mem_data[7:0]),
    .pop          (fifo_pop),
    .dout         (tx_data),
    .empty        (fifo_empty),
    .full         (fifo_full),
    .count        (fifo_count),
    .overflow_evt (fifo_ovf_evt)
  );

  assign tx_valid = ~fifo_empty;

  // RAM write port; contents survive reset
  always_ff @(posedge clk) begin
    if (wr_ok && region == REG_RAM) ram[word_idx] <= mem_data;
  end

  // Next ovf/cycle: an overflow in the same cycle as a CTRL clear leaves ovf set
  always_comb begin
    cycle_d = cycle_q + 32'd1;
    ovf_d   = ovf_q;
    if (ctrl_clr)     ovf_d = 1'b0;
    if (fifo_ovf_evt) ovf_d = 1'b1;
  end

  // Sticky overflow flag and free-running cycle counter
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q   <= 1'b0;
      cycle_q <= '0;
    end else begin
      ovf_q   <= ovf_d;
      cycle_q <= cycle_d;
    end
  end

  assign status_word = pack_status(ovf_q, fifo_full, fifo_empty, ST_CNT_W'(fifo_count));

  // Read mux: RAM word, MMIO register, or zero for unmapped space
  always_comb begin
    mem_out = '0;
    case (region)
      REG_RAM:  mem_out = ram[word_idx];
      REG_MMIO: begin
        case (mmio_off)
          OFF_STATUS: mem_out = status_word;
          OFF_CYCLE:  mem_out = cycle_q;
          default:    mem_out = '0;
        endcase
      end
      default:  mem_out = '0;
    endcase
  end

endmodule

// File: tb/tb_data_memory_mmio.sv
// Bench for data_memory_mmio: directed vectors with literal expectations plus a
// queue/array reference model compared against the outputs every cycle.
module tb_data_memory_mmio;

  localparam logic [31:0] A_TX = 32'hFFFF_0000;
  localparam logic [31:0] A_ST = 32'hFFFF_0004;
  localparam logic [31:0] A_CY = 32'hFFFF_0008;
  localparam logic [31:0] A_CT = 32'hFFFF_000C;
  localparam int          DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset, mem_en, tx_ready, tx_valid;
  logic [31:0] addr, mem_data, mem_out;
  logic [7:0]  tx_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_memory_mmio dut (
    .clk      (clk),
    .reset    (reset),
    .mem_en   (mem_en),
    .addr     (addr),
    .mem_data (mem_data),
    .mem_out  (mem_out),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] ram_m [int unsigned];
  logic [7:0]  q_m [$];
  bit          ovf_m;
  logic [31:0] cyc_m;
  bit          model_ok = 0;

  function automatic bit is_mmio(input logic [31:0] a);
    return a[31:4] == 28'hFFFF000;
  endfunction

  function automatic void model_read(input logic [31:0] a, output logic [31:0] v,
                                     output bit known);
    int n;
    known = 1;
    v = 32'd0;
    n = q_m.size();
    if (a < 32'd4096) begin
      if (ram_m.exists(a >> 2)) v = ram_m[a >> 2];
      else known = 0;
    end else if (is_mmio(a)) begin
      case (a[3:2])
        2'd1: v = (ovf_m ? 128 : 0) + (n == DEPTH ? 64 : 0) + (n == 0 ? 32 : 0) + n;
        2'd2: v = cyc_m;
        default: v = 32'd0;
      endcase
    end
  endfunction

  always @(posedge clk) begin
    int  pre;
    bit  popped, pushv, clr, setv;
    if (reset) begin
      q_m.delete();
      ovf_m    = 0;
      cyc_m    = 32'd0;
      model_ok = 1;
    end else if (model_ok) begin
      pre    = q_m.size();
      popped = tx_ready && pre > 0;
      pushv  = mem_en && is_mmio(addr) && addr[3:2] == 2'd0;
      clr    = mem_en && is_mmio(addr) && addr[3:2] == 2'd3 && mem_data[0];
      setv   = 0;
      cyc_m  = cyc_m + 32'd1;
      if (popped) void'(q_m.pop_front());
      if (pushv) begin
        if (pre < DEPTH || popped) q_m.push_back(mem_data[7:0]);
        else setv = 1;
      end
      if (clr)  ovf_m = 0;
      if (setv) ovf_m = 1;
      if (mem_en && addr < 32'd4096) ram_m[addr >> 2] = mem_data;
    end
  end

  // Compare DUT against the model mid-cycle, every cycle once reset has been seen
  always @(negedge clk) begin
    logic [31:0] ev;
    bit          known;
    if (model_ok) begin
      model_read(addr, ev, known);
      if (known) chk("model_mem_out", mem_out, ev);
      chk("model_tx_valid", {31'd0, tx_valid}, {31'd0, q_m.size() > 0});
      if (q_m.size() > 0) chk("model_tx_data", {24'd0, tx_data}, {24'd0, q_m[0]});
    end
  end

  // One bus cycle: present inputs, sample mem_out mid-cycle, advance past the edge
  task automatic op(input bit en, input logic [31:0] a, input logic [31:0] d,
                    output logic [31:0] rv);
    mem_en   = en;
    addr     = a;
    mem_data = d;
    @(negedge clk);
    rv = mem_out;
    @(posedge clk);
    #1;
    mem_en = 1'b0;
  endtask

  task automatic drain(input logic [7:0] exp [$], input string nm);
    tx_ready = 1'b1;
    foreach (exp[i]) begin
      @(negedge clk);
      chk({nm, "_valid"}, {31'd0, tx_valid}, 32'd1);
      chk({nm, "_byte"}, {24'd0, tx_data}, {24'd0, exp[i]});
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk({nm, "_empty_after"}, {31'd0, tx_valid}, 32'd0);
    @(posedge clk);
    #1;
    tx_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    errors++;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $fatal(1);
  end

  initial begin
    logic [31:0] v, v1, v2;
    logic [7:0]  exp_q [$];

    reset = 1'b1; mem_en = 1'b0; addr = 32'd0; mem_data = 32'd0; tx_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    op(0, A_CY, 0, v);  chk("reset_cycle", v, 32'd0);
    chk("reset_tx_valid", {31'd0, tx_valid}, 32'd0);
    op(0, A_ST, 0, v);  chk("reset_status", v, 32'h20);

    // RAM write/read, old value during write cycle
    op(1, 32'h10, 32'h1111_1111, v);
    op(1, 32'h10, 32'hDEAD_BEEF, v);  chk("ram_old_in_write_cycle", v, 32'h1111_1111);
    op(0, 32'h10, 0, v);              chk("ram_readback", v, 32'hDEAD_BEEF);
    op(1, 32'h0FFC, 32'hCAFE_F00D, v);
    op(0, 32'h0FFC, 0, v);            chk("ram_top_word", v, 32'hCAFE_F00D);
    op(0, 32'h1000, 0, v);            chk("past_ram_unmapped", v, 32'd0);

    // Three bytes queued, then drained in order
    op(1, A_TX, 32'h41, v);
    op(1, A_TX, 32'h42, v);
    op(1, A_TX, 32'h43, v);
    op(0, A_ST, 0, v);                chk("status_three", v, 32'h03);
    exp_q = '{8'h41, 8'h42, 8'h43};
    drain(exp_q, "drain_abc");
    op(0, A_ST, 0, v);                chk("status_after_drain", v, 32'h20);

    // Overflow: DEPTH+1 pushes with no consumer
    for (int i = 0; i <= DEPTH; i++) op(1, A_TX, 32'h60 + i, v);
    op(0, A_ST, 0, v);                chk("status_overflow", v, 32'hC8);
    op(1, A_CT, 32'h1, v);
    op(0, A_ST, 0, v);                chk("status_ovf_cleared", v, 32'h48);

    // Push and pop while full: count holds, no overflow, new byte lands last
    tx_ready = 1'b1;
    op(1, A_TX, 32'h55, v);
    tx_ready = 1'b0;
    op(0, A_ST, 0, v);                chk("status_full_push_pop", v, 32'h48);
    exp_q = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h55};
    drain(exp_q, "drain_full");

    // Cycle counter distance
    op(0, A_CY, 0, v1);
    repeat (5) op(0, 32'h20, 0, v);
    op(0, A_CY, 0, v2);
    chk("cycle_delta", v2 - v1, 32'd6);

    // Reset mid-run discards queued bytes and ignores writes
    op(1, A_TX, 32'h77, v);
    op(1, A_TX, 32'h78, v);
    reset = 1'b1;
    op(1, 32'h10, 32'h9999_9999, v);
    op(1, A_TX, 32'h79, v);
    reset = 1'b0;
    op(0, A_CY, 0, v);                chk("cycle_after_reset", v, 32'd0);
    chk("tx_valid_after_reset", {31'd0, tx_valid}, 32'd0);
    op(0, A_ST, 0, v);                chk("status_after_reset", v, 32'h20);
    op(0, 32'h10, 0, v);              chk("ram_kept_over_reset", v, 32'hDEAD_BEEF);

    // Unmapped space
    op(1, 32'h0, 32'h1234_5678, v);
    op(0, 32'h8000_0000, 0, v);       chk("unmapped_read", v, 32'd0);
    op(1, 32'h8000_0000, 32'hAAAA_5555, v);
    op(1, 32'hFFFF_0010, 32'hAB, v);
    op(0, 32'h0, 0, v);               chk("ram0_after_unmapped_write", v, 32'h1234_5678);
    op(0, A_ST, 0, v);                chk("status_after_unmapped_write", v, 32'h20);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
